// File: rtl/alu_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// alu_trigger_ctrl
//
// Trigger/operand sequencer for a transport-triggered ALU, sitting directly
// upstream of alu_unit, plus the in-order buffer that holds ALU results until
// the bus consumes them.
//
//  - Operand-A moves load a persistent A register.
//  - A trigger move (B operand + operator) fires alu_unit one cycle after it is
//    accepted. alu_unit returns its result one cycle later, and that result is
//    pushed into the result FIFO at the end of that cycle.
//  - DIV/MOD with B == 0 never reaches alu_unit. An all-ones result with the
//    error flag set travels down the same two-stage slot, so results leave in
//    trigger order.
//  - Credits: every op in the issue stage, in the capture stage or in the FIFO
//    holds one credit. Triggers are refused once RES_DEPTH credits are taken,
//    so the FIFO can never overflow.
//
// Operator encoding (oper_i / alu_oper_o):
//   0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, 6 AND, 7 OR, 8 XOR,
//   9 SLL, 10 SRL, 11 LT.
// Any code other than NOP is forwarded to alu_unit, except a screened DIV/MOD.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   a_we_i        operand-A move strobe
//   a_data_i      operand-A value
//   b_we_i        trigger move strobe (B operand + operator)
//   b_data_i      operand-B value
//   oper_i        operator for this trigger
//   trig_ready_o  a trigger can be accepted this cycle
//   alu_sel_o     alu_unit fire strobe (one cycle per issued op)
//   alu_oper_o    alu_unit operator (holds the last issued value)
//   alu_a_o       alu_unit operand A (holds the last issued value)
//   alu_b_o       alu_unit operand B (holds the last issued value)
//   alu_data_i    alu_unit result, valid the cycle after alu_sel_o
//   res_valid_o   result FIFO head valid
//   res_data_o    result FIFO head data (0 when empty)
//   res_err_o     head is a screened divide/modulo by zero (0 when empty)
//   res_ready_i   consumer pops the head when res_valid_o & res_ready_i
//   busy_o        any op in issue/capture stage or FIFO non-empty
// -----------------------------------------------------------------------------
module alu_trigger_ctrl #(
    parameter int DATA_W    = 32,
    parameter int OPER_W    = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_we_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_we_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic [OPER_W-1:0] oper_i,
    output logic              trig_ready_o,
    output logic              alu_sel_o,
    output logic [OPER_W-1:0] alu_oper_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_err_o,
    input  logic              res_ready_i,
    output logic              busy_o
);

    // Only the operator codes that need special handling are named here.
    localparam logic [OPER_W-1:0] OP_NOP = OPER_W'(0);
    localparam logic [OPER_W-1:0] OP_DIV = OPER_W'(4);
    localparam logic [OPER_W-1:0] OP_MOD = OPER_W'(5);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    // Wide enough to hold fifo_count + 2 without wrapping.
    localparam int SUM_W = CNT_W + 2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RES_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_DEPTH);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] a_q;

    // Issue stage: the op accepted in the previous cycle.
    logic              issue_v;
    logic              issue_err;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OPER_W-1:0] alu_oper_q;

    // Capture stage: alu_unit is presenting this op's result now.
    logic              capture_v;
    logic              capture_err;

    // Result FIFO
    logic [DATA_W-1:0] fifo_data [RES_DEPTH];
    logic              fifo_err  [RES_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    // -------------------------------------------------------------------------
    // Trigger decode
    // -------------------------------------------------------------------------
    logic              accept;
    logic              is_nop;
    logic              is_screen;
    logic              launch;
    logic [DATA_W-1:0] a_eff;
    logic [SUM_W-1:0]  credits_used;

    // An A move in the same cycle as the trigger is forwarded to the trigger.
    assign a_eff     = a_we_i ? a_data_i : a_q;
    assign is_nop    = (oper_i == OP_NOP);
    assign is_screen = ((oper_i == OP_DIV) || (oper_i == OP_MOD)) && (b_data_i == '0);

    // A same-cycle pop is deliberately left out: its credit becomes free only
    // once fifo_count has dropped, one cycle later. This keeps trig_ready_o
    // independent of res_ready_i.
    assign credits_used = SUM_W'(fifo_count) + SUM_W'(issue_v) + SUM_W'(capture_v);

    // Gated by rst_ni so that the port reads 0 while reset is held, even
    // though the credit counters alone would report room.
    assign trig_ready_o = rst_ni && (credits_used < SUM_W'(RES_DEPTH));

    assign accept = b_we_i && trig_ready_o;
    // A NOP is accepted but takes no credit and produces no result.
    assign launch = accept && !is_nop;

    // -------------------------------------------------------------------------
    // Operand A register
    // -------------------------------------------------------------------------
    // NOTE: every clocked register is written with non-blocking assignments so
    // that all flops sample the pre-edge values, whatever the statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= '0;
        end else if (a_we_i) begin
            a_q <= a_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Issue stage
    // -------------------------------------------------------------------------
    // A screened op still occupies the issue slot, so its error result lands in
    // the FIFO in trigger order. It leaves the alu_unit operand registers
    // untouched, so they keep showing the last op that really fired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_v    <= 1'b0;
            issue_err  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_oper_q <= '0;
        end else begin
            issue_v   <= launch;
            issue_err <= launch && is_screen;
            if (launch && !is_screen) begin
                alu_a_q    <= a_eff;
                alu_b_q    <= b_data_i;
                alu_oper_q <= oper_i;
            end
        end
    end

    assign alu_sel_o  = issue_v && !issue_err;
    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_oper_o = alu_oper_q;

    // -------------------------------------------------------------------------
    // Capture stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            capture_v   <= 1'b0;
            capture_err <= 1'b0;
        end else begin
            capture_v   <= issue_v;
            capture_err <= issue_err;
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO
    // -------------------------------------------------------------------------
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    // For a screened op, alu_unit was never fired, so alu_data_i is ignored.
    assign push      = capture_v;
    assign push_data = capture_err ? '1 : alu_data_i;
    assign pop       = res_valid_o && res_ready_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: the payload array has no reset. Only pointers and count decide what
    // is visible, and the outputs below are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= capture_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // A push and a pop in the same cycle leave the count unchanged,
            // including when the FIFO is full.
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    assign res_valid_o = (fifo_count != '0);
    // The head is read straight from storage, so it stays stable until popped.
    assign res_data_o  = res_valid_o ? fifo_data[rd_ptr] : '0;
    assign res_err_o   = res_valid_o && fifo_err[rd_ptr];

    assign busy_o = issue_v || capture_v || res_valid_o;

    // The credit rule makes a push into a full FIFO without a pop unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (fifo_count == CNT_FULL)));

endmodule

// File: tb/tb_alu_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_trigger_ctrl
//
// Cycle-based bench for alu_trigger_ctrl. Each step() call runs one clock
// cycle. At the falling edge, step() compares the DUT outputs with a
// transaction-level model, then drives that cycle's inputs.
//
// The model holds a queue of expected results. Each entry records the earliest
// cycle at which it may appear at the FIFO head. A trigger is expected to be
// accepted while fewer than RES_DEPTH results are outstanding, where a result
// stays outstanding until the cycle after it is popped.
//
// A small stand-in for alu_unit answers each alu_sel_o pulse one cycle later.
// In all other cycles it drives random data.
// -----------------------------------------------------------------------------
module tb_alu_trigger_ctrl;

    localparam int DATA_W = 32;
    localparam int OPER_W = 4;
    localparam int DEPTH  = 2;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_LT  = 4'd11;

    logic              clk_i;
    logic              rst_ni;
    logic              a_we_i;
    logic [DATA_W-1:0] a_data_i;
    logic              b_we_i;
    logic [DATA_W-1:0] b_data_i;
    logic [OPER_W-1:0] oper_i;
    logic              trig_ready_o;
    logic              alu_sel_o;
    logic [OPER_W-1:0] alu_oper_o;
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [DATA_W-1:0] alu_data_i;
    logic              res_valid_o;
    logic [DATA_W-1:0] res_data_o;
    logic              res_err_o;
    logic              res_ready_i;
    logic              busy_o;

    alu_trigger_ctrl #(
        .DATA_W   (DATA_W),
        .OPER_W   (OPER_W),
        .RES_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .a_we_i      (a_we_i),
        .a_data_i    (a_data_i),
        .b_we_i      (b_we_i),
        .b_data_i    (b_data_i),
        .oper_i      (oper_i),
        .trig_ready_o(trig_ready_o),
        .alu_sel_o   (alu_sel_o),
        .alu_oper_o  (alu_oper_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_data_i  (alu_data_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_err_o   (res_err_o),
        .res_ready_i (res_ready_i),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (step %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".trig_ready"}, 32'(trig_ready_o), 32'd0);
        check({tag, ".alu_sel"},    32'(alu_sel_o),    32'd0);
        check({tag, ".alu_oper"},   32'(alu_oper_o),   32'd0);
        check({tag, ".alu_a"},      alu_a_o,           32'd0);
        check({tag, ".alu_b"},      alu_b_o,           32'd0);
        check({tag, ".res_valid"},  32'(res_valid_o),  32'd0);
        check({tag, ".res_data"},   res_data_o,        32'd0);
        check({tag, ".res_err"},    32'(res_err_o),    32'd0);
        check({tag, ".busy"},       32'(busy_o),       32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Operator semantics, used for expected results and by the alu_unit stand-in
    // -------------------------------------------------------------------------
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_MOD:  return (b == 0) ? 32'hFFFF_FFFF : a % b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_LT:   return 32'(a < b);
            default: return 32'd0;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Reference model state
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          avail;   // first step at which the entry may be at the head
    } exp_t;

    exp_t        q[$];
    logic [31:0] a_reg;
    logic        pend_sel;
    logic [31:0] pend_a, pend_b;
    logic [3:0]  pend_op;
    logic [31:0] last_a, last_b;
    logic [3:0]  last_op;
    logic        last_acc;

    // alu_unit stand-in state: the op seen on the previous step
    logic        stub_sel;
    logic [31:0] stub_a, stub_b;
    logic [3:0]  stub_op;

    task automatic model_reset();
        q.delete();
        a_reg    = '0;
        pend_sel = 1'b0;
        pend_a   = '0;
        pend_b   = '0;
        pend_op  = '0;
        last_a   = '0;
        last_b   = '0;
        last_op  = '0;
        last_acc = 1'b0;
        stub_sel = 1'b0;
        stub_a   = '0;
        stub_b   = '0;
        stub_op  = '0;
    endtask

    // One clock cycle: check the outputs, drive the inputs, advance the model.
    task automatic step(input logic awe, input logic [31:0] ad, input logic bwe,
                        input logic [31:0] bd, input logic [3:0] op, input logic rdy);
        logic        exp_valid;
        logic        exp_ready;
        logic        acc;
        logic        screen;
        logic [31:0] aeff;
        exp_t        e;

        @(negedge clk_i);

        // alu_unit stand-in: answers the previous cycle's fire strobe.
        alu_data_i = stub_sel ? alu_ref(stub_a, stub_b, stub_op) : $urandom;
        stub_sel   = alu_sel_o;
        stub_a     = alu_a_o;
        stub_b     = alu_b_o;
        stub_op    = alu_oper_o;

        if (pend_sel) begin
            last_a  = pend_a;
            last_b  = pend_b;
            last_op = pend_op;
        end
        exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
        exp_ready = (q.size() < DEPTH);

        check("alu_sel",    32'(alu_sel_o),    32'(pend_sel));
        check("alu_a",      alu_a_o,           last_a);
        check("alu_b",      alu_b_o,           last_b);
        check("alu_oper",   32'(alu_oper_o),   32'(last_op));
        check("trig_ready", 32'(trig_ready_o), 32'(exp_ready));
        check("res_valid",  32'(res_valid_o),  32'(exp_valid));
        check("busy",       32'(busy_o),       32'(q.size() > 0));
        if (exp_valid) begin
            check("res_data", res_data_o,       q[0].data);
            check("res_err",  32'(res_err_o),   32'(q[0].err));
        end

        a_we_i      = awe;
        a_data_i    = ad;
        b_we_i      = bwe;
        b_data_i    = bd;
        oper_i      = op;
        res_ready_i = rdy;

        aeff = awe ? ad : a_reg;
        if (awe) a_reg = ad;
        acc      = bwe && exp_ready;
        last_acc = acc;
        if (rdy && exp_valid) void'(q.pop_front());
        pend_sel = 1'b0;
        if (acc && (op != OP_NOP)) begin
            screen  = ((op == OP_DIV) || (op == OP_MOD)) && (bd == 0);
            e.data  = screen ? 32'hFFFF_FFFF : alu_ref(aeff, bd, op);
            e.err   = screen;
            e.avail = cyc + 3;
            q.push_back(e);
            if (!screen) begin
                pend_sel = 1'b1;
                pend_a   = aeff;
                pend_b   = bd;
                pend_op  = op;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, OP_NOP, rdy);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic        done;
        logic [31:0] b_rand;
        logic [3:0]  op_rand;

        rst_ni      = 1'b1;
        a_we_i      = 1'b0;
        a_data_i    = '0;
        b_we_i      = 1'b0;
        b_data_i    = '0;
        oper_i      = '0;
        res_ready_i = 1'b0;
        alu_data_i  = '0;
        model_reset();

        #1 rst_ni = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: A=5, then ADD with B=3 gives 8 at minimum latency.
        step(1'b1, 32'd5, 1'b0, 32'd0, OP_NOP, 1'b1);
        step(1'b0, 32'd0, 1'b1, 32'd3, OP_ADD, 1'b1);
        idle(4, 1'b1);

        // 2: consumer stalled; the third trigger is refused and retried.
        step(1'b1, 32'd1, 1'b0, 32'd0, OP_NOP, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'd1, OP_ADD, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'd2, OP_ADD, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'd3, OP_ADD, 1'b0);
        check("t2_third_refused", 32'(last_acc), 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd3, OP_ADD, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'd3, OP_ADD, 1'b0);
        done = last_acc;
        for (int i = 0; i < 10 && !done; i++) begin
            step(1'b0, 32'd0, 1'b1, 32'd3, OP_ADD, 1'b1);
            done = last_acc;
        end
        check("t2_retry_accepted", 32'(done), 32'd1);
        idle(5, 1'b1);

        // 3: same-cycle A write is forwarded; A persists for the next trigger.
        step(1'b1, 32'd7, 1'b1, 32'd2, OP_SUB, 1'b1);
        step(1'b0, 32'd0, 1'b1, 32'd1, OP_SUB, 1'b1);
        idle(5, 1'b1);

        // 4: divide by zero is screened, then MUL 7*6.
        step(1'b0, 32'd0, 1'b1, 32'd0, OP_DIV, 1'b1);
        step(1'b1, 32'd7, 1'b1, 32'd6, OP_MUL, 1'b1);
        step(1'b0, 32'd0, 1'b1, 32'd0, OP_MOD, 1'b1);
        idle(5, 1'b1);

        // 5: NOP trigger does nothing.
        step(1'b0, 32'd0, 1'b1, 32'd9, OP_NOP, 1'b1);
        idle(4, 1'b1);

        // 6: reset with two ops outstanding (one buffered, one in capture).
        step(1'b1, 32'd1, 1'b1, 32'd1, OP_ADD, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'd2, OP_ADD, 1'b0);
        step(1'b0, 32'd0, 1'b0, 32'd0, OP_NOP, 1'b0);
        step(1'b0, 32'd0, 1'b0, 32'd0, OP_NOP, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("mid_reset");
        model_reset();
        b_we_i = 1'b0;
        a_we_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(3, 1'b1);
        step(1'b1, 32'd2, 1'b1, 32'd2, OP_ADD, 1'b1);
        idle(5, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            op_rand = 4'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0:       b_rand = 32'd0;
                1:       b_rand = 32'($urandom_range(0, 9));
                default: b_rand = $urandom;
            endcase
            step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) < 6,
                 b_rand, op_rand, $urandom_range(0, 9) < 7);
        end
        idle(10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
